// File: rtl/ct_pkg.sv
// Shared definitions for the control-transfer unit: opcode encodings, FSM states
// and the redirect-target helper.
package ct_pkg;

    localparam int unsigned CT_OP_W = 4;

    localparam logic [CT_OP_W-1:0] CT_B    = 4'd0;
    localparam logic [CT_OP_W-1:0] CT_BEQ  = 4'd1;
    localparam logic [CT_OP_W-1:0] CT_BNE  = 4'd2;
    localparam logic [CT_OP_W-1:0] CT_BLT  = 4'd3;
    localparam logic [CT_OP_W-1:0] CT_BGE  = 4'd4;
    localparam logic [CT_OP_W-1:0] CT_BLTU = 4'd5;
    localparam logic [CT_OP_W-1:0] CT_J    = 4'd6;
    localparam logic [CT_OP_W-1:0] CT_JAL  = 4'd7;
    localparam logic [CT_OP_W-1:0] CT_JR   = 4'd8;
    localparam logic [CT_OP_W-1:0] CT_JALR = 4'd9;

    typedef enum logic {
        CT_IDLE     = 1'b0,
        CT_REDIRECT = 1'b1
    } ct_state_e;

    // Redirect target; branch offsets wrap silently modulo 2^32.
    function automatic logic [31:0] ct_target(
        input logic [CT_OP_W-1:0] op,
        input logic [31:0]        pc,
        input logic [31:0]        imm,
        input logic [31:0]        rs
    );
        logic [31:0] pc4;
        logic [31:0] tgt;
        pc4 = pc + 32'd4;
        case (op)
            CT_J, CT_JAL:   tgt = {pc4[31:28], imm[25:0], 2'b00};
            CT_JR, CT_JALR: tgt = {rs[31:2], 2'b00};
            default:        tgt = pc4 + {imm[29:0], 2'b00};
        endcase
        return tgt;
    endfunction

endpackage

// File: rtl/ct_cond_eval.sv
// Combinational branch-condition evaluation; undefined opcodes evaluate as not taken.
module ct_cond_eval
    import ct_pkg::*;
#(
    parameter int unsigned OP_W = 4
) (
    input  logic [OP_W-1:0] ex_op,
    input  logic [31:0]     rs_val,
    input  logic [31:0]     rt_val,
    output logic            cond_true
);

    logic [CT_OP_W-1:0] op;

    always_comb begin
        op        = CT_OP_W'(ex_op);
        cond_true = 1'b0;
        case (op)
            CT_B, CT_J, CT_JAL, CT_JR, CT_JALR: cond_true = 1'b1;
            CT_BEQ:  cond_true = (rs_val == rt_val);
            CT_BNE:  cond_true = (rs_val != rt_val);
            CT_BLT:  cond_true = ($signed(rs_val) <  $signed(rt_val));
            CT_BGE:  cond_true = ($signed(rs_val) >= $signed(rt_val));
            CT_BLTU: cond_true = (rs_val < rt_val);
            default: cond_true = 1'b0;
        endcase
    end

endmodule

// File: rtl/control_transfer_unit.sv
// Resolves branches/jumps and holds the redirect until the PC consumes it (en_f=0).
// Optional performance counters are enabled with the CT_PERF_EN macro.
module control_transfer_unit
    import ct_pkg::*;
#(
    parameter int unsigned OP_W = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            hlt,
    input  logic            en_f,
    input  logic            ex_valid,
    input  logic [OP_W-1:0] ex_op,
    input  logic [31:0]     pc_ex,
    input  logic [31:0]     imm,
    input  logic [31:0]     rs_val,
    input  logic [31:0]     rt_val,
    output logic            ct_taken,
    output logic [31:0]     ct_pc,
    output logic            link_we,
    output logic [31:0]     link_data,
    output logic            busy,
    output logic [31:0]     taken_cnt,
    output logic [31:0]     nottaken_cnt
);

    ct_state_e          state_q, state_d;
    logic               taken_d;
    logic [31:0]        pc_d;
    logic               link_we_d;
    logic [31:0]        link_data_d;
    logic               cond_true;
    logic               accept;
    logic [CT_OP_W-1:0] op;

    ct_cond_eval #(.OP_W(OP_W)) u_cond (
        .ex_op     (ex_op),
        .rs_val    (rs_val),
        .rt_val    (rt_val),
        .cond_true (cond_true)
    );

    assign op     = CT_OP_W'(ex_op);
    assign accept = !hlt && (state_q == CT_IDLE) && ex_valid;
    assign busy   = (state_q == CT_REDIRECT);

    // Next-state and registered-output values; hlt overrides everything.
    always_comb begin
        state_d     = state_q;
        taken_d     = ct_taken;
        pc_d        = ct_pc;
        link_we_d   = 1'b0;
        link_data_d = link_data;
        if (hlt) begin
            state_d = CT_IDLE;
            taken_d = 1'b0;
        end else begin
            case (state_q)
                CT_IDLE: begin
                    if (ex_valid && cond_true) begin
                        state_d = CT_REDIRECT;
                        taken_d = 1'b1;
                        pc_d    = ct_target(op, pc_ex, imm, rs_val);
                        if (op == CT_JAL || op == CT_JALR) begin
                            link_we_d   = 1'b1;
                            link_data_d = pc_ex + 32'd4;
                        end
                    end
                end
                CT_REDIRECT: begin
                    // ct_pc stays valid on this edge so the PC loads it.
                    if (!en_f) begin
                        state_d = CT_IDLE;
                        taken_d = 1'b0;
                    end
                end
                default: begin
                    state_d = CT_IDLE;
                    taken_d = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= CT_IDLE;
            ct_taken  <= 1'b0;
            ct_pc     <= '0;
            link_we   <= 1'b0;
            link_data <= '0;
        end else begin
            state_q   <= state_d;
            ct_taken  <= taken_d;
            ct_pc     <= pc_d;
            link_we   <= link_we_d;
            link_data <= link_data_d;
        end
    end

`ifdef CT_PERF_EN
    logic [31:0] taken_q;
    logic [31:0] nottaken_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            taken_q    <= '0;
            nottaken_q <= '0;
        end else if (accept) begin
            if (cond_true) taken_q    <= taken_q + 32'd1;
            else           nottaken_q <= nottaken_q + 32'd1;
        end
    end

    assign taken_cnt    = taken_q;
    assign nottaken_cnt = nottaken_q;
`else
    logic perf_unused;
    assign perf_unused  = accept;
    assign taken_cnt    = '0;
    assign nottaken_cnt = '0;
`endif

endmodule

// File: tb/tb_control_transfer_unit.sv
// Scoreboard bench for control_transfer_unit: a high-level model pushes per-cycle
// expectations, a monitor pops and compares them after every rising edge.
module tb_control_transfer_unit;
    import ct_pkg::*;

    logic        clk = 1'b0;
    logic        rst, hlt, en_f, ex_valid;
    logic [3:0]  ex_op;
    logic [31:0] pc_ex, imm, rs_val, rt_val;
    logic        ct_taken, link_we, busy;
    logic [31:0] ct_pc, link_data, taken_cnt, nottaken_cnt;

    control_transfer_unit #(.OP_W(4)) dut (
        .clk          (clk),
        .rst          (rst),
        .hlt          (hlt),
        .en_f         (en_f),
        .ex_valid     (ex_valid),
        .ex_op        (ex_op),
        .pc_ex        (pc_ex),
        .imm          (imm),
        .rs_val       (rs_val),
        .rt_val       (rt_val),
        .ct_taken     (ct_taken),
        .ct_pc        (ct_pc),
        .link_we      (link_we),
        .link_data    (link_data),
        .busy         (busy),
        .taken_cnt    (taken_cnt),
        .nottaken_cnt (nottaken_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        taken;
        logic [31:0] pc;
        logic        lwe;
        logic [31:0] ld;
        logic [31:0] tc;
        logic [31:0] nc;
    } exp_t;

    exp_t q[$];
    int   n_chk  = 0;
    int   n_fail = 0;

    // Reference model state: one optional pending redirect plus counters.
    bit          m_pend;
    bit          m_lwe;
    logic [31:0] m_pc, m_ld, m_tc, m_nc;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit ref_taken(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        if (op == CT_B || op == CT_J || op == CT_JAL || op == CT_JR || op == CT_JALR) return 1'b1;
        if (op == CT_BEQ)  return a == b;
        if (op == CT_BNE)  return a != b;
        if (op == CT_BLT)  return int'(a) <  int'(b);
        if (op == CT_BGE)  return int'(a) >= int'(b);
        if (op == CT_BLTU) return a < b;
        return 1'b0;
    endfunction

    function automatic logic [31:0] ref_target(input logic [3:0] op, input logic [31:0] pc,
                                               input logic [31:0] im, input logic [31:0] a);
        if (op == CT_J || op == CT_JAL)
            return ((pc + 32'd4) & 32'hF000_0000) | ((im & 32'h03FF_FFFF) * 32'd4);
        if (op == CT_JR || op == CT_JALR)
            return a & ~32'd3;
        return pc + 32'd4 + im * 32'd4;
    endfunction

    // Drive one cycle of inputs, advance the model across the coming edge, queue the result.
    task automatic cyc(input bit r, input bit h, input bit ef, input bit ev, input logic [3:0] op,
                       input logic [31:0] pc, input logic [31:0] im,
                       input logic [31:0] a, input logic [31:0] b);
        exp_t e;
        @(negedge clk);
        rst = r; hlt = h; en_f = ef; ex_valid = ev; ex_op = op;
        pc_ex = pc; imm = im; rs_val = a; rt_val = b;
        if (r) begin
            m_pend = 0; m_lwe = 0; m_pc = '0; m_ld = '0; m_tc = '0; m_nc = '0;
        end else begin
            m_lwe = 0;
            if (h) m_pend = 0;
            else if (m_pend) begin
                if (!ef) m_pend = 0;
            end else if (ev) begin
                if (ref_taken(op, a, b)) begin
                    m_pend = 1;
                    m_pc   = ref_target(op, pc, im, a);
                    if (op == CT_JAL || op == CT_JALR) begin
                        m_lwe = 1;
                        m_ld  = pc + 32'd4;
                    end
                    m_tc = m_tc + 32'd1;
                end else begin
                    m_nc = m_nc + 32'd1;
                end
            end
        end
        e.taken = m_pend;
        e.pc    = m_pc;
        e.lwe   = m_lwe;
        e.ld    = m_ld;
`ifdef CT_PERF_EN
        e.tc = m_tc;
        e.nc = m_nc;
`else
        e.tc = '0;
        e.nc = '0;
`endif
        q.push_back(e);
    endtask

    task automatic idle(input bit ef);
        cyc(0, 0, ef, 0, CT_B, 32'h0, 32'h0, 32'h0, 32'h0);
    endtask

    // Monitor: compare every observable output once per cycle against the queue head.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() != 0) begin
                e = q.pop_front();
                chk("ct_taken",     32'(ct_taken), 32'(e.taken));
                chk("busy",         32'(busy),     32'(e.taken));
                chk("ct_pc",        ct_pc,         e.pc);
                chk("link_we",      32'(link_we),  32'(e.lwe));
                chk("link_data",    link_data,     e.ld);
                chk("taken_cnt",    taken_cnt,     e.tc);
                chk("nottaken_cnt", nottaken_cnt,  e.nc);
            end
        end
    end

    initial begin
        logic [31:0] a, b;
        rst = 1; hlt = 0; en_f = 0; ex_valid = 0; ex_op = '0;
        pc_ex = '0; imm = '0; rs_val = '0; rt_val = '0;
        m_pend = 0; m_lwe = 0; m_pc = '0; m_ld = '0; m_tc = '0; m_nc = '0;
        #1;
        chk("reset_taken", 32'(ct_taken), 32'd0);
        chk("reset_pc",    ct_pc,         32'd0);
        chk("reset_busy",  32'(busy),     32'd0);
        cyc(1, 0, 0, 0, CT_B, 0, 0, 0, 0);
        cyc(1, 0, 0, 0, CT_B, 0, 0, 0, 0);

        // BEQ taken, consumed on the next edge
        cyc(0, 0, 0, 1, CT_BEQ, 32'h100, 32'd3, 32'd5, 32'd5);
        idle(0); idle(0);
        // signed vs unsigned compare of the same operands
        cyc(0, 0, 0, 1, CT_BLT, 32'h200, 32'd2, 32'hFFFF_FFFF, 32'd1);
        idle(0);
        cyc(0, 0, 0, 1, CT_BLTU, 32'h200, 32'd2, 32'hFFFF_FFFF, 32'd1);
        idle(0);
        // JAL held while fetch stays enabled for 3 edges
        cyc(0, 0, 1, 1, CT_JAL, 32'h4000_0010, 32'h0000_0040, 32'h0, 32'h0);
        idle(1); idle(1); idle(1); idle(0); idle(0);
        // JALR with a protocol-violating second ex_valid while pending
        cyc(0, 0, 1, 1, CT_JALR, 32'h500, 32'h0, 32'h1237, 32'h0);
        cyc(0, 0, 1, 1, CT_J, 32'h600, 32'h123, 32'h0, 32'h0);
        idle(0); idle(0);
        // branch target wraps past 2^32
        cyc(0, 0, 0, 1, CT_B, 32'hFFFF_FFF8, 32'd1, 32'h0, 32'h0);
        idle(0);
        // halt drops the pending redirect and beats a new ex_valid
        cyc(0, 0, 1, 1, CT_J, 32'h700, 32'h55, 32'h0, 32'h0);
        cyc(0, 1, 1, 1, CT_JAL, 32'h800, 32'h66, 32'h0, 32'h0);
        idle(1);
        // asynchronous reset while a redirect is pending
        cyc(0, 0, 1, 1, CT_JR, 32'h900, 32'h0, 32'hABCD_0003, 32'h0);
        cyc(1, 0, 1, 0, CT_B, 0, 0, 0, 0);
        #1;
        chk("async_rst_taken", 32'(ct_taken), 32'd0);
        chk("async_rst_pc",    ct_pc,         32'd0);
        chk("async_rst_busy",  32'(busy),     32'd0);
        cyc(1, 0, 0, 0, CT_B, 0, 0, 0, 0);

        // randomized traffic, including undefined opcodes and rare halts/resets
        for (int i = 0; i < 600; i++) begin
            a = $urandom();
            b = ($urandom_range(0, 3) == 0) ? a : $urandom();
            if ($urandom_range(0, 3) == 0) begin
                a = 32'($urandom_range(0, 4)) - 32'd2;
                b = 32'($urandom_range(0, 4)) - 32'd2;
            end
            cyc(($urandom_range(0, 99) == 0), ($urandom_range(0, 24) == 0),
                ($urandom_range(0, 2) == 0) ? 1'b0 : 1'b1, $urandom_range(0, 1) == 1,
                4'($urandom_range(0, 15)), $urandom(), $urandom(), a, b);
        end
        idle(0); idle(0);
        repeat (3) @(posedge clk);
        #2;
        chk("queue_drain", 32'(q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
